// File: rtl/ans_pkg.sv
// Shared parameters and state encoding for the ANS symbol scheduler.
// Imported by the scheduler top and its count/cumulative table.
package ans_pkg;

    localparam int SYM_WIDTH = 2;
    localparam int SYM_COUNT = 2 ** SYM_WIDTH;
    localparam int CNT_WIDTH = 8;
    localparam int CUM_WIDTH = CNT_WIDTH + SYM_WIDTH;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_SCAN = 2'd1,
        ST_RUN  = 2'd2,
        ST_ERR  = 2'd3
    } ans_state_e;

endpackage

// File: rtl/ans_table.sv
// Per-symbol count and exclusive-cumulative storage for the ANS scheduler.
// Counts are read at the scan index and the symbol index; cum at the symbol index.
module ans_table
    import ans_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cnt_we,
    input  logic [SYM_WIDTH-1:0] cnt_waddr,
    input  logic [CNT_WIDTH-1:0] cnt_wdata,
    input  logic                 cum_we,
    input  logic [SYM_WIDTH-1:0] cum_waddr,
    input  logic [CUM_WIDTH-1:0] cum_wdata,
    input  logic [SYM_WIDTH-1:0] scan_idx,
    output logic [CNT_WIDTH-1:0] scan_cnt,
    input  logic [SYM_WIDTH-1:0] sym_idx,
    output logic [CNT_WIDTH-1:0] sym_cnt,
    output logic [CUM_WIDTH-1:0] sym_cum
);

    logic [CNT_WIDTH-1:0] counts_r [SYM_COUNT];
    logic [CUM_WIDTH-1:0] cum_r    [SYM_COUNT];

    // Table storage; contents survive a restart and are cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYM_COUNT; i++) begin
                counts_r[i] <= '0;
                cum_r[i]    <= '0;
            end
        end else begin
            if (cnt_we) begin
                counts_r[cnt_waddr] <= cnt_wdata;
            end
            if (cum_we) begin
                cum_r[cum_waddr] <= cum_wdata;
            end
        end
    end

    assign scan_cnt = counts_r[scan_idx];
    assign sym_cnt  = counts_r[sym_idx];
    assign sym_cum  = cum_r[sym_idx];

endmodule

// File: rtl/ans_sched.sv
// ANS encode scheduler: loads a frequency table, builds cumulative counts,
// then maps each incoming symbol to its (freq, cum) pair for the coder datapath.
module ans_sched
    import ans_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 restart,
    input  logic [CNT_WIDTH-1:0] cfg_in,
    input  logic                 cfg_vld,
    output logic                 cfg_rdy,
    input  logic [SYM_WIDTH-1:0] sym_in,
    input  logic                 sym_last,
    input  logic                 sym_vld,
    output logic                 sym_rdy,
    output logic [CNT_WIDTH-1:0] enc_freq,
    output logic [CUM_WIDTH-1:0] enc_cum,
    output logic                 enc_last,
    output logic                 enc_vld,
    input  logic                 enc_rdy,
    output logic [CUM_WIDTH-1:0] enc_total,
    output logic                 busy,
    output logic                 err
);

    localparam logic [SYM_WIDTH-1:0] LAST_IDX = SYM_WIDTH'(SYM_COUNT - 1);

    ans_state_e           state_r;
    ans_state_e           state_nxt_s;
    logic [SYM_WIDTH-1:0] idx_r;
    logic [CUM_WIDTH-1:0] acc_r;
    logic                 cfg_rdy_r;
    logic [CNT_WIDTH-1:0] enc_freq_r;
    logic [CUM_WIDTH-1:0] enc_cum_r;
    logic                 enc_last_r;
    logic                 enc_vld_r;
    logic [CUM_WIDTH-1:0] enc_total_r;

    logic                 sym_rdy_s;
    logic                 busy_s;
    logic                 err_s;
    logic                 cfg_fire_s;
    logic                 sym_fire_s;
    logic                 cnt_we_s;
    logic                 cum_we_s;
    logic [CNT_WIDTH-1:0] scan_cnt_s;
    logic [CNT_WIDTH-1:0] sym_cnt_s;
    logic [CUM_WIDTH-1:0] sym_cum_s;
    logic [CUM_WIDTH-1:0] acc_sum_s;

    assign cfg_fire_s = (state_r == ST_LOAD) && cfg_vld && cfg_rdy_r;
    assign sym_fire_s = sym_vld && sym_rdy_s;
    assign cnt_we_s   = cfg_fire_s && !restart;
    assign cum_we_s   = (state_r == ST_SCAN) && !restart;
    // Zero-extended add cannot overflow: SYM_COUNT max counts fit in CUM_WIDTH.
    assign acc_sum_s  = acc_r + {{(CUM_WIDTH - CNT_WIDTH){1'b0}}, scan_cnt_s};

    ans_table u_table (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_we    (cnt_we_s),
        .cnt_waddr (idx_r),
        .cnt_wdata (cfg_in),
        .cum_we    (cum_we_s),
        .cum_waddr (idx_r),
        .cum_wdata (acc_r),
        .scan_idx  (idx_r),
        .scan_cnt  (scan_cnt_s),
        .sym_idx   (sym_in),
        .sym_cnt   (sym_cnt_s),
        .sym_cum   (sym_cum_s)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; restart overrides every other event.
    always_comb begin
        state_nxt_s = state_r;
        if (restart) begin
            state_nxt_s = ST_LOAD;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (cfg_fire_s && (idx_r == LAST_IDX)) begin
                        state_nxt_s = ST_SCAN;
                    end else begin
                        state_nxt_s = ST_LOAD;
                    end
                end
                ST_SCAN: begin
                    if (idx_r != LAST_IDX) begin
                        state_nxt_s = ST_SCAN;
                    end else if (acc_sum_s == '0) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (sym_fire_s && (sym_cnt_s == '0)) begin
                        state_nxt_s = ST_ERR;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_ERR:  state_nxt_s = ST_ERR;
                default: state_nxt_s = ST_LOAD;
            endcase
        end
    end

    // State-decoded outputs; sym_rdy lets a new symbol in whenever the output slot frees.
    always_comb begin
        sym_rdy_s = 1'b0;
        busy_s    = 1'b0;
        err_s     = 1'b0;
        case (state_r)
            ST_LOAD: busy_s = 1'b1;
            ST_SCAN: busy_s = 1'b1;
            ST_RUN:  sym_rdy_s = !enc_vld_r || enc_rdy;
            ST_ERR:  err_s = 1'b1;
            default: busy_s = 1'b1;
        endcase
    end

    // Datapath: config handshake, scan accumulator and the registered encode word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= '0;
            acc_r       <= '0;
            cfg_rdy_r   <= 1'b1;
            enc_freq_r  <= '0;
            enc_cum_r   <= '0;
            enc_last_r  <= 1'b0;
            enc_vld_r   <= 1'b0;
            enc_total_r <= '0;
        end else if (restart) begin
            idx_r     <= '0;
            enc_vld_r <= 1'b0;
            cfg_rdy_r <= 1'b1;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    if (cfg_fire_s) begin
                        idx_r     <= idx_r + 1'b1;
                        cfg_rdy_r <= 1'b0;
                        if (idx_r == LAST_IDX) begin
                            acc_r <= '0;
                        end
                    end else if (!cfg_vld && !cfg_rdy_r) begin
                        cfg_rdy_r <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    idx_r <= idx_r + 1'b1;
                    acc_r <= acc_sum_s;
                    if (idx_r == LAST_IDX) begin
                        enc_total_r <= acc_sum_s;
                    end
                end
                ST_RUN: begin
                    if (sym_fire_s) begin
                        if (sym_cnt_s == '0) begin
                            enc_vld_r <= 1'b0;
                        end else begin
                            enc_freq_r <= sym_cnt_s;
                            enc_cum_r  <= sym_cum_s;
                            enc_last_r <= sym_last;
                            enc_vld_r  <= 1'b1;
                        end
                    end else if (enc_rdy) begin
                        enc_vld_r <= 1'b0;
                    end
                end
                ST_ERR:  enc_vld_r <= 1'b0;
                default: enc_vld_r <= 1'b0;
            endcase
        end
    end

    assign cfg_rdy   = cfg_rdy_r;
    assign sym_rdy   = sym_rdy_s;
    assign enc_freq  = enc_freq_r;
    assign enc_cum   = enc_cum_r;
    assign enc_last  = enc_last_r;
    assign enc_vld   = enc_vld_r;
    assign enc_total = enc_total_r;
    assign busy      = busy_s;
    assign err       = err_s;

endmodule

// File: doc/ans_sched.md
ANS_SCHED -- requirements
Module: ans_sched

Interface
REQ-001 Parameters (from shared package): SYM_WIDTH, default 2, symbol index bits; SYM_COUNT, default 2**SYM_WIDTH, alphabet size; CNT_WIDTH, default 8, per-symbol count bits; CUM_WIDTH, default CNT_WIDTH+SYM_WIDTH, cumulative/total bits.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 restart  input  1  synchronous abort; forces table reload.
REQ-005 cfg_in  input  CNT_WIDTH  count word for symbol idx (idx implied by arrival order 0..SYM_COUNT-1).
REQ-006 cfg_vld / cfg_rdy  input / output  1 / 1  four-phase handshake for cfg_in.
REQ-007 sym_in  input  SYM_WIDTH  symbol to encode.
REQ-008 sym_last  input  1  marks final symbol of a message.
REQ-009 sym_vld / sym_rdy  input / output  1 / 1  valid/ready handshake for sym_in, sym_last.
REQ-010 enc_freq  output  CNT_WIDTH  count of issued symbol.
REQ-011 enc_cum  output  CUM_WIDTH  exclusive cumulative count of issued symbol.
REQ-012 enc_last  output  1  copy of sym_last for issued symbol.
REQ-013 enc_vld / enc_rdy  output / input  1 / 1  valid/ready handshake to coder datapath.
REQ-014 enc_total  output  CUM_WIDTH  sum of all counts; stable in RUN.
REQ-015 busy  output  1  high in LOAD and SCAN.
REQ-016 err  output  1  high in ERR.

Function
REQ-017 States: LOAD, SCAN, RUN, ERR; one-hot or binary at implementer's choice.
REQ-018 LOAD: cfg_rdy=1 and cfg_vld=1 at edge -> counts[idx]<=cfg_in, idx++, cfg_rdy<=0; cfg_rdy<=1 again only after a cycle with cfg_vld=0.
REQ-019 LOAD: accepting word idx=SYM_COUNT-1 -> SCAN next cycle, idx<=0, acc<=0; cfg_rdy stays 0 outside LOAD.
REQ-020 SCAN: one entry per cycle: cum[idx]<=acc, acc<=acc+counts[idx]; exactly SYM_COUNT cycles.
REQ-021 SCAN end: enc_total<=final acc; total==0 -> ERR, else RUN.
REQ-022 RUN: sym_rdy = !enc_vld || enc_rdy (combinational); sym_rdy=0 in all other states.
REQ-023 RUN accept: enc_freq<=counts[sym_in], enc_cum<=cum[sym_in], enc_last<=sym_last, enc_vld<=1; latency 1 cycle, full throughput.
REQ-024 enc_vld and enc_* held stable until enc_rdy; enc_rdy with no new accept clears enc_vld.
REQ-025 RUN accept of symbol with counts[sym]==0 -> enc_vld<=0, symbol dropped, ERR next cycle.
REQ-026 enc_last handshake leaves state in RUN; table reused for next message.
REQ-027 ERR: err=1, all ready outputs 0, enc_vld=0; exit only via restart or reset.
REQ-028 restart has priority over every event: next state LOAD, idx<=0, enc_vld<=0, cfg_rdy<=1, err<=0; table contents retained until overwritten.
REQ-029 acc arithmetic in CUM_WIDTH bits; cannot overflow (SYM_COUNT*(2**CNT_WIDTH-1) fits).

Reset
REQ-030 rst_n low: state LOAD, idx=0, acc=0, cfg_rdy=1, sym_rdy=0, enc_vld=0, enc_freq=0, enc_cum=0, enc_last=0, enc_total=0, busy=1, err=0, all counts and cum entries 0.
REQ-031 Reset assertion mid-transfer discards any partial table and outstanding enc_* word.

Structure
REQ-032 SYM_WIDTH, SYM_COUNT, CNT_WIDTH, CUM_WIDTH and state encoding live in shared package ans_pkg.
REQ-033 counts/cum storage in sub-module ans_table: one write port each, two combinational read ports (scan index, symbol index).

Verification (SYM_WIDTH=2, CNT_WIDTH=8)
REQ-034 Load 3,0,5,8 with four-phase handshake -> cfg_rdy drops each accept, SCAN 4 cycles, RUN with enc_total=16, cum=0,3,3,8.
REQ-035 RUN, enc_rdy=1, symbols 3,2,0 back-to-back -> enc (8,8),(5,3),(3,0) on consecutive cycles after 1-cycle latency.
REQ-036 enc_rdy=0 three cycles with symbol 2 pending -> enc_vld held, enc_*=(5,3) stable, sym_rdy=0.
REQ-037 Symbol 1 (count 0) in RUN -> no enc_vld, err=1 next cycle; restart -> LOAD, err=0, cfg_rdy=1.
REQ-038 Load 0,0,0,0 -> ERR after SCAN, enc_total=0.
REQ-039 restart after two loaded words, then reload 1,1,1,1 -> enc_total=4, cum=0,1,2,3.
